code_lock: RTL and testbench
============================

Name: code_lock

Overview:
Parametrised keypad code lock and the successor to the fixed 8-bit sequence lock. It accepts a stream of CODE_LEN digits, each DIGIT_W bits wide, and compares them against a code that can be reprogrammed at run time. It adds a failed-attempt counter with timed lockout, automatic relock after a hold time, and a programming mode. It sits between the keypad debouncer/encoder and the door actuator/LED drivers.

Parameters:
DIGIT_W, 4, bits per key digit
CODE_LEN, 4, digits per code (>=1)
MAX_TRIES, 3, consecutive failed entries before lockout (>=1)
UNLOCK_CYC, 500, cycles the door stays unlocked; also the programming-mode timeout (>=1)
LOCKOUT_CYC, 1000, cycles keys are ignored after MAX_TRIES failures (>=1)
DEFAULT_CODE, 16'h4321, reset code, CODE_LEN*DIGIT_W bits; digit i = DEFAULT_CODE[i*DIGIT_W +: DIGIT_W]; digit 0 is entered first

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
key_valid  in  1  one-cycle strobe; key_digit is valid this cycle
key_digit  in  DIGIT_W  entered digit
key_clear  in  1  discard the partial entry; no failure is counted
relock  in  1  force relock from UNLOCKED
prog_req  in  1  enter programming mode (honoured only in UNLOCKED)
locked  out  1  door locked indicator
unlocked  out  1  door unlocked indicator (always equal to ~locked)
error  out  1  one-cycle pulse on a wrong complete entry
lockout  out  1  high while in LOCKOUT
prog_active  out  1  high while in PROG
prog_done  out  1  one-cycle pulse when a new code is committed
fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive failures so far

Behaviour:
- Reset (async, rst=0):
  - State LOCKED; idx=0, mismatch=0, timer=0, fail_cnt=0.
  - Code register = DEFAULT_CODE.
  - Outputs: locked=1, unlocked=0, error=0, lockout=0, prog_active=0, prog_done=0.
  - Reset asserted mid-entry, mid-unlock or mid-programming aborts the operation. A partially programmed code is discarded; the code register returns to DEFAULT_CODE.
- All outputs are registered. A response appears in the cycle after the key_valid that causes it.
- State machine (states LOCKED, UNLOCKED, LOCKOUT, PROG):
  - LOCKED, on key_valid:
    - mismatch |= (key_digit != code digit idx); idx increments.
    - On the CODE_LEN-th digit with the accumulated result matching: go to UNLOCKED, timer=UNLOCK_CYC, fail_cnt=0.
    - On the CODE_LEN-th digit with a mismatch: error pulses, fail_cnt increments, idx and mismatch clear.
    - If fail_cnt reaches MAX_TRIES: go to LOCKOUT, timer=LOCKOUT_CYC.
  - LOCKED, key_clear: idx=0 and mismatch=0. If key_valid is in the same cycle, key_clear wins and the digit is dropped.
  - UNLOCKED:
    - Timer decrements each cycle; at expiry go to LOCKED. unlocked is high for exactly UNLOCK_CYC cycles.
    - relock: go to LOCKED next cycle.
    - prog_req: go to PROG, timer=UNLOCK_CYC. If relock and prog_req arrive together, relock wins.
    - key_valid is ignored.
  - PROG:
    - Each key_valid writes the digit into the shadow register at idx.
    - After the CODE_LEN-th digit: the code register takes the shadow value, prog_done pulses, go to LOCKED. The new code is effective for the very next entry.
    - key_clear restarts the shadow entry at idx=0.
    - Timeout: abort with the code unchanged, go to LOCKED. locked stays 0 throughout PROG.
  - LOCKOUT:
    - key_valid, key_clear and prog_req are ignored.
    - At timer expiry go to LOCKED, fail_cnt=0, idx=0.
- Every entry to LOCKED clears idx and mismatch.
- Timer width is $clog2(max(UNLOCK_CYC,LOCKOUT_CYC)+1). No wrap: the timer holds at 0.
- fail_cnt saturates at MAX_TRIES.

Test Plan:
- Params DIGIT_W=4, CODE_LEN=4, UNLOCK_CYC=8. Reset, then key digits 1,2,3,4 -> unlocked=1 the cycle after digit 4; held exactly 8 cycles; then locked=1.
- MAX_TRIES=3, LOCKOUT_CYC=16. Enter 1,2,3,5 three times -> error pulses 3 times; fail_cnt 1,2,3; lockout=1 for 16 cycles. Digits sent during lockout are ignored. Afterwards fail_cnt=0, and 1,2,3,4 unlocks.
- Enter 1,2, then key_clear, then 1,2,3,4 -> unlocks with no error and fail_cnt=0. key_valid together with key_clear -> digit dropped.
- Unlock, then prog_req, then digits 9,8,7,6 -> prog_done pulse and locked=1. Entry 1,2,3,4 -> error; entry 9,8,7,6 -> unlocked.
- Unlock, assert relock and prog_req in the same cycle -> locked=1 and prog_active=0. Then enter PROG, key 2 digits, let the timer expire -> code unchanged, 1,2,3,4 still unlocks.
- Unlock, then pull rst low for 1 cycle mid-unlock -> locked=1 immediately (async). After a reprogram, rst restores DEFAULT_CODE.

Source files
------------

// File: rtl/code_lock_if.sv
// code_lock_if: keypad-side and indicator-side signals of the code lock.
//   Keypad -> lock : key_valid, key_digit, key_clear, relock, prog_req
//   Lock -> drivers: locked, unlocked, error, lockout, prog_active,
//                    prog_done, fail_cnt
// The master modport is the keypad/controller side; slave is the lock.
// DIGIT_W and MAX_TRIES must match the parameters of the attached lock.
interface code_lock_if #(
    parameter int DIGIT_W   = 4,
    parameter int MAX_TRIES = 3
);
    logic                             key_valid;
    logic [DIGIT_W-1:0]               key_digit;
    logic                             key_clear;
    logic                             relock;
    logic                             prog_req;
    logic                             locked;
    logic                             unlocked;
    logic                             error;
    logic                             lockout;
    logic                             prog_active;
    logic                             prog_done;
    logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt;

    modport master (
        output key_valid, key_digit, key_clear, relock, prog_req,
        input  locked, unlocked, error, lockout, prog_active, prog_done, fail_cnt
    );

    modport slave (
        input  key_valid, key_digit, key_clear, relock, prog_req,
        output locked, unlocked, error, lockout, prog_active, prog_done, fail_cnt
    );
endinterface

// File: rtl/code_lock.sv
// code_lock: reprogrammable keypad code lock with failed-attempt lockout,
// timed relock and a programming mode.
//   clk  : clock
//   rst  : asynchronous reset, active-low
//   bus  : code_lock_if.slave (keypad strobes in, indicator outputs out)
// Digit i of the code is code[i*DIGIT_W +: DIGIT_W]; digit 0 is keyed first.
// All outputs are registered, so a response shows up the cycle after the
// key strobe that caused it.
module code_lock #(
    parameter int DIGIT_W     = 4,
    parameter int CODE_LEN    = 4,
    parameter int MAX_TRIES   = 3,
    parameter int UNLOCK_CYC  = 500,
    parameter int LOCKOUT_CYC = 1000,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h4321
) (
    input  logic        clk,
    input  logic        rst,
    code_lock_if.slave  bus
);
    localparam int CODE_W  = CODE_LEN * DIGIT_W;
    localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int FC_W    = $clog2(MAX_TRIES + 1);
    localparam int TMR_MAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CODE_LEN - 1);
    localparam logic [FC_W-1:0]  FC_MAX    = FC_W'(MAX_TRIES);
    localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(MAX_TRIES - 1);
    localparam logic [TMR_W-1:0] T_UNLOCK  = TMR_W'(UNLOCK_CYC);
    localparam logic [TMR_W-1:0] T_LOCKOUT = TMR_W'(LOCKOUT_CYC);

    typedef enum logic [1:0] {S_LOCKED, S_UNLOCKED, S_LOCKOUT, S_PROG} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic               mismatch;
    logic [TMR_W-1:0]   timer;
    logic [FC_W-1:0]    fail_cnt;
    logic [CODE_W-1:0]  code;
    logic [CODE_W-1:0]  shadow;
    logic [CODE_W-1:0]  shadow_wr;

    logic locked_r, unlocked_r, error_r, lockout_r, prog_active_r, prog_done_r;
    logic locked_nxt, lockout_nxt, prog_active_nxt, error_nxt, prog_done_nxt;

    function automatic logic [DIGIT_W-1:0] digit_at(input logic [CODE_W-1:0] c,
                                                    input logic [IDX_W-1:0]  i);
        digit_at = '0;
        for (int k = 0; k < CODE_LEN; k++)
            if (i == IDX_W'(k)) digit_at = c[k*DIGIT_W +: DIGIT_W];
    endfunction

    // key_clear always beats a simultaneous digit.
    logic key_take, last_key, digit_miss, timer_exp;
    logic entry_ok, entry_bad, commit;

    assign key_take   = bus.key_valid & ~bus.key_clear;
    assign last_key   = key_take & (idx == LAST_IDX);
    assign digit_miss = mismatch | (bus.key_digit != digit_at(code, idx));
    assign timer_exp  = (timer <= TMR_W'(1));
    assign entry_ok   = (state == S_LOCKED) & last_key & ~digit_miss;
    assign entry_bad  = (state == S_LOCKED) & last_key &  digit_miss;
    assign commit     = (state == S_PROG)   & last_key;

    // Shadow value with the current digit merged in; committed as-is on the
    // final digit so the new code is usable on the very next entry.
    always_comb begin
        shadow_wr = shadow;
        for (int k = 0; k < CODE_LEN; k++)
            if (idx == IDX_W'(k)) shadow_wr[k*DIGIT_W +: DIGIT_W] = bus.key_digit;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_LOCKED;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOCKED: begin
                if (entry_ok)
                    state_nxt = S_UNLOCKED;
                else if (entry_bad && fail_cnt >= FC_LAST)
                    state_nxt = S_LOCKOUT;
            end
            S_UNLOCKED: begin
                // relock has priority over prog_req, both over expiry.
                if (bus.relock)        state_nxt = S_LOCKED;
                else if (bus.prog_req) state_nxt = S_PROG;
                else if (timer_exp)    state_nxt = S_LOCKED;
            end
            S_PROG: begin
                // A final digit landing on the last cycle still commits.
                if (commit || timer_exp) state_nxt = S_LOCKED;
            end
            S_LOCKOUT: begin
                if (timer_exp) state_nxt = S_LOCKED;
            end
            default: state_nxt = S_LOCKED;
        endcase
    end

    // Output logic (next values of the registered indicators)
    always_comb begin
        locked_nxt      = (state_nxt == S_LOCKED) || (state_nxt == S_LOCKOUT);
        lockout_nxt     = (state_nxt == S_LOCKOUT);
        prog_active_nxt = (state_nxt == S_PROG);
        error_nxt       = entry_bad;
        prog_done_nxt   = commit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx           <= '0;
            mismatch      <= 1'b0;
            timer         <= '0;
            fail_cnt      <= '0;
            code          <= DEFAULT_CODE;
            locked_r      <= 1'b1;
            unlocked_r    <= 1'b0;
            error_r       <= 1'b0;
            lockout_r     <= 1'b0;
            prog_active_r <= 1'b0;
            prog_done_r   <= 1'b0;
        end else begin
            // Any state change or a rejected entry restarts digit collection.
            if (state_nxt != state || entry_bad) begin
                idx      <= '0;
                mismatch <= 1'b0;
            end else if ((state == S_LOCKED || state == S_PROG) && bus.key_clear) begin
                idx      <= '0;
                mismatch <= 1'b0;
            end else if ((state == S_LOCKED || state == S_PROG) && bus.key_valid) begin
                idx      <= idx + IDX_W'(1);
                mismatch <= digit_miss;
            end

            if (state_nxt == S_LOCKOUT && state != S_LOCKOUT)
                timer <= T_LOCKOUT;
            else if ((state_nxt == S_UNLOCKED && state != S_UNLOCKED) ||
                     (state_nxt == S_PROG && state != S_PROG))
                timer <= T_UNLOCK;
            else if (timer != '0)
                timer <= timer - TMR_W'(1);

            if (entry_ok)
                fail_cnt <= '0;
            else if (entry_bad && fail_cnt != FC_MAX)
                fail_cnt <= fail_cnt + FC_W'(1);
            else if (state == S_LOCKOUT && state_nxt == S_LOCKED)
                fail_cnt <= '0;

            if (commit) code <= shadow_wr;

            locked_r      <= locked_nxt;
            unlocked_r    <= ~locked_nxt;
            error_r       <= error_nxt;
            lockout_r     <= lockout_nxt;
            prog_active_r <= prog_active_nxt;
            prog_done_r   <= prog_done_nxt;
        end
    end

    // The shadow is pure data: every slot is rewritten before a commit.
    always_ff @(posedge clk) begin
        if (state == S_PROG && key_take) shadow <= shadow_wr;
    end

    assign bus.locked      = locked_r;
    assign bus.unlocked    = unlocked_r;
    assign bus.error       = error_r;
    assign bus.lockout     = lockout_r;
    assign bus.prog_active = prog_active_r;
    assign bus.prog_done   = prog_done_r;
    assign bus.fail_cnt    = fail_cnt;
endmodule

// File: tb/tb_code_lock.sv
// tb_code_lock: scoreboard bench for code_lock. A driver applies one input
// vector per cycle, steps a behavioural model (digit queue + remaining-time
// counters) and pushes the expected indicators; a monitor pops and compares.
module tb_code_lock;
    localparam int DW = 4;
    localparam int CL = 4;
    localparam int MT = 3;
    localparam int UC = 8;
    localparam int LC = 16;
    localparam logic [CL*DW-1:0] DEF = 16'h4321;

    typedef struct packed {
        logic       locked;
        logic       unlocked;
        logic       error;
        logic       lockout;
        logic       prog_active;
        logic       prog_done;
        logic [1:0] fail_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    code_lock_if #(.DIGIT_W(DW), .MAX_TRIES(MT)) bus ();

    code_lock #(
        .DIGIT_W(DW), .CODE_LEN(CL), .MAX_TRIES(MT),
        .UNLOCK_CYC(UC), .LOCKOUT_CYC(LC), .DEFAULT_CODE(DEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural model state
    int   open_left, prog_left, ban_left, fails;
    int   entered[$];
    int   shadow[$];
    int   mcode[CL];
    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic exp_t model_out(logic err, logic done);
        exp_t e;
        e.locked      = !(open_left > 0 || prog_left > 0);
        e.unlocked    = (open_left > 0 || prog_left > 0);
        e.error       = err;
        e.lockout     = (ban_left > 0);
        e.prog_active = (prog_left > 0);
        e.prog_done   = done;
        e.fail_cnt    = 2'(fails);
        return e;
    endfunction

    task automatic model_reset();
        logic [CL*DW-1:0] dc;
        dc = DEF;
        open_left = 0; prog_left = 0; ban_left = 0; fails = 0;
        entered.delete();
        shadow.delete();
        for (int i = 0; i < CL; i++) mcode[i] = int'(dc[i*DW +: DW]);
    endtask

    task automatic model_step(input logic kv, input int kd, input logic kc,
                              input logic rl, input logic pr, output exp_t e);
        logic err, done, match;
        err = 1'b0; done = 1'b0;
        if (ban_left > 0) begin
            ban_left--;
            if (ban_left == 0) begin
                fails = 0;
                entered.delete();
            end
        end else if (open_left > 0) begin
            if (rl) open_left = 0;
            else if (pr) begin
                open_left = 0;
                prog_left = UC;
                shadow.delete();
            end else open_left--;
        end else if (prog_left > 0) begin
            if (kc) shadow.delete();
            else if (kv) shadow.push_back(kd);
            if (shadow.size() == CL) begin
                for (int i = 0; i < CL; i++) mcode[i] = shadow[i];
                done = 1'b1;
                prog_left = 0;
                entered.delete();
            end else begin
                prog_left--;
            end
        end else begin
            if (kc) entered.delete();
            else if (kv) begin
                entered.push_back(kd);
                if (entered.size() == CL) begin
                    match = 1'b1;
                    for (int i = 0; i < CL; i++)
                        if (entered[i] != mcode[i]) match = 1'b0;
                    entered.delete();
                    if (match) begin
                        open_left = UC;
                        fails = 0;
                    end else begin
                        err = 1'b1;
                        if (fails < MT) fails++;
                        if (fails >= MT) ban_left = LC;
                    end
                end
            end
        end
        e = model_out(err, done);
    endtask

    task automatic cycle(input logic kv, input int kd, input logic kc,
                         input logic rl, input logic pr);
        exp_t e;
        @(negedge clk);
        rst           = 1'b1;
        bus.key_valid = kv;
        bus.key_digit = DW'(kd);
        bus.key_clear = kc;
        bus.relock    = rl;
        bus.prog_req  = pr;
        model_step(kv, kd, kc, rl, pr, e);
        q.push_back(e);
    endtask

    task automatic key(input int d);
        cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter(input int a, input int b, input int c, input int d);
        key(a); key(b); key(c); key(d);
    endtask

    // Asynchronous reset: outputs must change before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_digit = '0;
        bus.key_clear = 1'b0;
        bus.relock    = 1'b0;
        bus.prog_req  = 1'b0;
        #2;
        chk("rst_async_locked",   int'(bus.locked), 1);
        chk("rst_async_unlocked", int'(bus.unlocked), 0);
        chk("rst_async_lockout",  int'(bus.lockout), 0);
        chk("rst_async_prog",     int'(bus.prog_active), 0);
        chk("rst_async_fail_cnt", int'(bus.fail_cnt), 0);
        model_reset();
        q.push_back(model_out(1'b0, 1'b0));
    endtask

    // Monitor: one expected record per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("locked",      int'(bus.locked),      int'(e.locked));
                chk("unlocked",    int'(bus.unlocked),    int'(e.unlocked));
                chk("error",       int'(bus.error),       int'(e.error));
                chk("lockout",     int'(bus.lockout),     int'(e.lockout));
                chk("prog_active", int'(bus.prog_active), int'(e.prog_active));
                chk("prog_done",   int'(bus.prog_done),   int'(e.prog_done));
                chk("fail_cnt",    int'(bus.fail_cnt),    int'(e.fail_cnt));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cc[CL];
        int r;
        bus.key_valid = 1'b0;
        bus.key_digit = '0;
        bus.key_clear = 1'b0;
        bus.relock    = 1'b0;
        bus.prog_req  = 1'b0;
        model_reset();

        // Basic unlock and timed relock
        do_reset();
        idle(2);
        enter(1, 2, 3, 4);
        idle(10);

        // Three bad entries, lockout, keys ignored, recovery
        enter(1, 2, 3, 5);
        enter(1, 2, 3, 5);
        enter(1, 2, 3, 5);
        enter(1, 2, 3, 4);
        idle(14);
        enter(1, 2, 3, 4);
        idle(10);

        // key_clear discards partial entry; clear wins over a digit
        key(1); key(2);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
        enter(1, 2, 3, 4);
        idle(10);
        key(1); key(2); key(3);
        cycle(1'b1, 4, 1'b1, 1'b0, 1'b0);
        enter(1, 2, 3, 4);
        idle(10);

        // Reprogram to 9,8,7,6
        enter(1, 2, 3, 4);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        enter(9, 8, 7, 6);
        idle(1);
        enter(1, 2, 3, 4);
        enter(9, 8, 7, 6);
        idle(10);

        // relock beats prog_req; programming timeout keeps the code
        do_reset();
        enter(1, 2, 3, 4);
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
        idle(2);
        enter(1, 2, 3, 4);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        key(2); key(7);
        idle(10);
        enter(1, 2, 3, 4);
        idle(10);

        // Reset mid-unlock, and reset after reprogramming
        enter(1, 2, 3, 4);
        idle(3);
        do_reset();
        idle(2);
        enter(1, 2, 3, 4);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        enter(9, 8, 7, 6);
        idle(2);
        do_reset();
        enter(1, 2, 3, 4);
        idle(10);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: begin
                    for (int i = 0; i < CL; i++) cc[i] = mcode[i];
                    for (int i = 0; i < CL; i++) key(cc[i]);
                end
                3: for (int i = 0; i < CL; i++) key($urandom_range(0, 15));
                4: cycle(1'b1, $urandom_range(0, 15), 1'b1, 1'b0, 1'b0);
                5: cycle(1'b0, 0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
                6: cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
                7: idle($urandom_range(1, 12));
                8: cycle(1'($urandom_range(0, 1)), $urandom_range(0, 15),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
                default: begin
                    if ($urandom_range(0, 9) == 0) do_reset();
                    else idle(1);
                end
            endcase
        end

        idle(2);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
